tick_sched: RTL and testbench
=============================

# tick_sched

Multi-channel periodic event scheduler driven by the one-pulse-per-period timer tick from the breath/timer block. Holds up to N_CH independently programmed interval counters, all clocked by the shared base tick. Raises a pending flag per channel when its interval expires, and delivers events one at a time to a downstream consumer through a valid/ready handshake with round-robin arbitration. Typical use: deriving LED patterns, watchdog kicks and periodic status reports from a single shared timer.

## Interface
- N_CH, 4: number of channels, 2..16
- CNT_W, 16: interval counter width in base ticks
- CH_W, $clog2(N_CH): channel index width (derived, not overridden)
- CLK_I  in  1  system clock, the same clock that drives the timer block
- RSTN_I  in  1  reset, asynchronous and active-low
- TICK_I  in  1  base tick, one-cycle pulse (timer TIMER_O)
- CFG_WE_I  in  1  configuration write strobe, one cycle
- CFG_CH_I  in  CH_W  channel being configured
- CFG_EN_I  in  1  channel enable value written
- CFG_INTERVAL_I  in  CNT_W  interval in ticks; 0 means disabled
- EVT_VALID_O  out  1  event presented
- EVT_CH_O  out  CH_W  channel of the presented event
- EVT_READY_I  in  1  consumer accepts the event
- PEND_O  out  N_CH  per-channel pending flags
- OVF_O  out  N_CH  sticky per-channel overrun flags

## Operation
- Per channel: en, interval, cnt, pend and ovf registers. A channel is active when en=1 and interval≠0.
- CFG write to channel c:
  - en, interval ← inputs; cnt ← CFG_INTERVAL_I.
  - pend[c] and ovf[c] are cleared.
  - Exception: if c is the currently presented channel (EVT_VALID_O=1, EVT_CH_O=c), pend[c] is kept and the event completes normally.
  - CFG_CH_I ≥ N_CH: the write is ignored.
- On TICK_I, each active channel:
  - If cnt==1: the channel is due and cnt ← interval.
  - Otherwise: cnt ← cnt−1.
  - Result: the first event comes N ticks after configuration, then one event every N ticks.
- Due handling: pend ← 1. If pend was already 1 and is not being cleared by a handshake in the same cycle, ovf ← 1 (sticky) and the extra event is dropped, never queued.
- Due in the same cycle as the handshake for that channel: pend stays 1, ovf is not set.
- CFG write and TICK_I in the same cycle on the same channel: the write wins and the tick is ignored for that channel. Other channels tick normally.
- Inactive channels do not count. pend is left untouched on disable except through the write-clear above.
- FSM has two states, IDLE and PRESENT:
  - IDLE: if any pend bit is set, pick the first set bit at or after rr_ptr (wrapping), register the channel into EVT_CH_O, set EVT_VALID_O=1, go to PRESENT.
  - PRESENT: EVT_VALID_O and EVT_CH_O are held stable. On EVT_READY_I=1: clear pend[ch], rr_ptr ← (ch+1) mod N_CH, EVT_VALID_O ← 0, go to IDLE.
- No withdrawal: once presented, an event stays until accepted, even if its channel is disabled meanwhile.

## Timing
- Reset values: EVT_VALID_O=0, EVT_CH_O=0, PEND_O=0, OVF_O=0; all en/interval/cnt=0; rr_ptr=0; FSM in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Tick latency: TICK_I at cycle t expires a channel → PEND_O set at t+1 → EVT_VALID_O=1 at t+2 (if FSM idle).
- Handshake: EVT_VALID_O and EVT_READY_I high together at cycle h → EVT_VALID_O=0 at h+1. The next event can be presented at h+2 at the earliest, giving a maximum throughput of one event per 2 cycles.
- Reset asserted mid-operation clears everything immediately. Counting resumes only after reconfiguration.
- Assumption: TICK_I period ≫ 2·N_CH cycles, so overrun arises only from a stalled consumer.

## Structure
- tick_sched_pkg holds:
  - state enum {IDLE, PRESENT}
  - default N_CH and CNT_W constants
  - a function that finds the next set bit in round-robin order (returns index plus found flag)
- Sub-module rr_arbiter(N_CH): combinational, inputs req vector and pointer, outputs grant index and valid. The FSM register lives in tick_sched.
- Per-channel counters are built with a generate loop inside tick_sched; no per-channel sub-module.

## Test plan
- Configure ch0 with interval=3, READY held at 1, TICK every 20 cycles → EVT_VALID_O pulses with ch=0 two cycles after the 3rd, 6th and 9th ticks; OVF_O=0.
- Configure ch0..ch3 all with interval=1, READY=1 → after each tick events arrive in order 0,1,2,3, two cycles apart; rr_ptr continues from 0 on the next tick.
- Configure ch2 with interval=2, READY=0 for 5 ticks → single event for ch2 held stable, OVF_O[2]=1, PEND_O[2]=1. Raise READY → one acceptance, PEND_O[2]=0, OVF_O[2] stays 1 until ch2 is rewritten.
- Write ch1 with interval=4 in the same cycle as TICK_I → the tick is ignored for ch1; the first ch1 event follows the 4th subsequent tick.
- Write ch1 with interval=0 while ch1 is presented → event still held and accepted once; no further ch1 events.
- Drop RSTN_I while EVT_VALID_O=1 → all outputs read 0 within the same cycle; no events after release without reconfiguration.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types, default sizes and the round-robin search used by the tick scheduler.
package tick_sched_pkg;

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_CH    = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Scans downward so the set bit closest to ptr (in wrapped order) is the last one written.
  function automatic rr_pick_t rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int n);
    rr_pick_t pick;
    int       j;
    pick = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j[3:0]]) begin
          pick.found = 1'b1;
          pick.idx   = j[3:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tick_sched_if.sv
// Configuration, tick and event handshake bundle of the tick scheduler.
interface tick_sched_if import tick_sched_pkg::*; #(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int CH_W = $clog2(N_CH)
);
  logic             TICK_I;
  logic             CFG_WE_I;
  logic [CH_W-1:0]  CFG_CH_I;
  logic             CFG_EN_I;
  logic [CNT_W-1:0] CFG_INTERVAL_I;
  logic             EVT_VALID_O;
  logic [CH_W-1:0]  EVT_CH_O;
  logic             EVT_READY_I;
  logic [N_CH-1:0]  PEND_O;
  logic [N_CH-1:0]  OVF_O;

  modport master (
    output TICK_I, CFG_WE_I, CFG_CH_I, CFG_EN_I, CFG_INTERVAL_I, EVT_READY_I,
    input  EVT_VALID_O, EVT_CH_O, PEND_O, OVF_O
  );

  modport slave (
    input  TICK_I, CFG_WE_I, CFG_CH_I, CFG_EN_I, CFG_INTERVAL_I, EVT_READY_I,
    output EVT_VALID_O, EVT_CH_O, PEND_O, OVF_O
  );
endinterface

// File: rtl/tick_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter import tick_sched_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            valid
);
  rr_pick_t pick;

  always_comb begin
    pick  = rr_next(MAX_CH'(req), int'(ptr), N_CH);
    grant = CH_W'(pick.idx);
    valid = pick.found;
  end
endmodule

// File: rtl/tick_sched.sv
// Multi-channel periodic event scheduler on a shared base tick with round-robin event delivery.
module tick_sched import tick_sched_pkg::*; #(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int CH_W = $clog2(N_CH)
) (
  input logic         CLK_I,
  input logic         RSTN_I,
  tick_sched_if.slave bus
);
  state_t          state, state_nx;
  logic            evt_valid, evt_valid_nx;
  logic [CH_W-1:0] evt_ch, evt_ch_nx;
  logic [CH_W-1:0] rr_ptr, rr_ptr_nx;
  logic [N_CH-1:0] pend, ovf, wr_hit, req;
  logic [CH_W-1:0] grant;
  logic            grant_valid;
  logic            hs;

  assign hs = (state == PRESENT) && bus.EVT_READY_I;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic             en;
    logic [CNT_W-1:0] interval;
    logic [CNT_W-1:0] cnt;
    logic             pend_r, ovf_r;
    logic             active, presented, hs_c, due;

    assign wr_hit[c] = bus.CFG_WE_I && (bus.CFG_CH_I == CH_W'(c));
    assign active    = en && (interval != '0);
    assign presented = evt_valid && (evt_ch == CH_W'(c));
    assign hs_c      = hs && (evt_ch == CH_W'(c));
    // A write on the same cycle as the tick takes priority, so the tick is lost for this channel.
    assign due       = bus.TICK_I && active && (cnt == CNT_W'(1)) && !wr_hit[c];

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
        en       <= 1'b0;
        interval <= '0;
        cnt      <= '0;
      end else if (wr_hit[c]) begin
        en       <= bus.CFG_EN_I;
        interval <= bus.CFG_INTERVAL_I;
        cnt      <= bus.CFG_INTERVAL_I;
      end else if (bus.TICK_I && active) begin
        cnt <= (cnt == CNT_W'(1)) ? interval : cnt - CNT_W'(1);
      end
    end

    // The presented channel keeps its pend through a rewrite so the handshake still completes.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
        pend_r <= 1'b0;
        ovf_r  <= 1'b0;
      end else if (wr_hit[c]) begin
        ovf_r  <= 1'b0;
        pend_r <= presented && pend_r && !hs_c;
      end else if (due) begin
        pend_r <= 1'b1;
        if (pend_r && !hs_c) ovf_r <= 1'b1;
      end else if (hs_c) begin
        pend_r <= 1'b0;
      end
    end

    assign pend[c] = pend_r;
    assign ovf[c]  = ovf_r;
  end

  // Channels being rewritten this cycle lose their pend, so they are not offered for arbitration.
  assign req = pend & ~wr_hit;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nx;
      evt_valid <= evt_valid_nx;
      evt_ch    <= evt_ch_nx;
      rr_ptr    <= rr_ptr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    evt_valid_nx = evt_valid;
    evt_ch_nx    = evt_ch;
    rr_ptr_nx    = rr_ptr;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nx     = PRESENT;
          evt_valid_nx = 1'b1;
          evt_ch_nx    = grant;
        end
      end
      PRESENT: begin
        if (bus.EVT_READY_I) begin
          state_nx     = IDLE;
          evt_valid_nx = 1'b0;
          rr_ptr_nx    = (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + CH_W'(1);
        end
      end
      default: begin
        state_nx     = IDLE;
        evt_valid_nx = 1'b0;
      end
    endcase
  end

  assign bus.EVT_VALID_O = evt_valid;
  assign bus.EVT_CH_O    = evt_ch;
  assign bus.PEND_O      = pend;
  assign bus.OVF_O       = ovf;
endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: expected (channel, cycle) pairs are queued as ticks are driven.
module tb_tick_sched;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int CH_W  = 2;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];
  exp_t e_m;

  tick_sched_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  tick_sched #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .CLK_I  (clk),
    .RSTN_I (rst_n),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each accepted event is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.EVT_VALID_O && bus.EVT_READY_I) begin
      if (q.size() == 0) begin
        check("evt_unexpected", int'(bus.EVT_CH_O), 99);
      end else begin
        e_m = q.pop_front();
        check("evt_ch", int'(bus.EVT_CH_O), e_m.ch);
        if (e_m.cyc >= 0) check("evt_cyc", cyc, e_m.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int en, input int iv);
    @(posedge clk);
    #1;
    bus.CFG_WE_I       = 1'b1;
    bus.CFG_CH_I       = CH_W'(ch);
    bus.CFG_EN_I       = 1'(en);
    bus.CFG_INTERVAL_I = CNT_W'(iv);
    @(posedge clk);
    #1;
    bus.CFG_WE_I = 1'b0;
  endtask

  task automatic tick_begin(output int k);
    @(posedge clk);
    #1;
    bus.TICK_I = 1'b1;
    k = cyc;
  endtask

  task automatic tick_end(input int gap);
    @(posedge clk);
    #1;
    bus.TICK_I   = 1'b0;
    bus.CFG_WE_I = 1'b0;
    idle(gap);
  endtask

  task automatic plain_ticks(input int n, input int gap);
    int k;
    for (int i = 0; i < n; i++) begin
      tick_begin(k);
      tick_end(gap);
    end
  endtask

  initial begin
    int k;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.TICK_I = 1'b0;
    bus.CFG_WE_I = 1'b0;
    bus.CFG_CH_I = '0;
    bus.CFG_EN_I = 1'b0;
    bus.CFG_INTERVAL_I = '0;
    bus.EVT_READY_I = 1'b0;
    idle(3);
    check("rst_valid", int'(bus.EVT_VALID_O), 0);
    check("rst_ch", int'(bus.EVT_CH_O), 0);
    check("rst_pend", int'(bus.PEND_O), 0);
    check("rst_ovf", int'(bus.OVF_O), 0);
    rst_n = 1'b1;
    idle(2);

    // ch0 every 3 ticks, consumer always ready
    bus.EVT_READY_I = 1'b1;
    cfg(0, 1, 3);
    for (int i = 1; i <= 9; i++) begin
      tick_begin(k);
      if (i % 3 == 0) q.push_back('{0, k + 2});
      tick_end(18);
    end
    check("t1_ovf", int'(bus.OVF_O), 0);
    check("t1_drain", q.size(), 0);
    cfg(0, 0, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // all four channels due on every tick
    for (int c = 0; c < N_CH; c++) cfg(c, 1, 1);
    for (int t = 0; t < 2; t++) begin
      tick_begin(k);
      for (int c = 0; c < N_CH; c++) q.push_back('{c, k + 2 + 2 * c});
      tick_end(18);
    end
    check("t2_drain", q.size(), 0);
    check("t2_ovf", int'(bus.OVF_O), 0);
    for (int c = 0; c < N_CH; c++) cfg(c, 0, 0);

    // stalled consumer on ch2 produces an overrun
    bus.EVT_READY_I = 1'b0;
    cfg(2, 1, 2);
    for (int i = 1; i <= 5; i++) begin
      tick_begin(k);
      tick_end(18);
      if (i >= 2) begin
        check("t3_hold_valid", int'(bus.EVT_VALID_O), 1);
        check("t3_hold_ch", int'(bus.EVT_CH_O), 2);
      end
    end
    check("t3_ovf", int'(bus.OVF_O), 4);
    check("t3_pend", int'(bus.PEND_O), 4);
    @(posedge clk);
    #1;
    bus.EVT_READY_I = 1'b1;
    q.push_back('{2, cyc});
    idle(3);
    check("t3_pend_clr", int'(bus.PEND_O), 0);
    check("t3_ovf_sticky", int'(bus.OVF_O), 4);
    check("t3_valid_off", int'(bus.EVT_VALID_O), 0);
    check("t3_drain", q.size(), 0);
    cfg(2, 0, 0);
    check("t3_ovf_wclr", int'(bus.OVF_O), 0);

    // ch1 rewritten on a tick cycle; ch3 keeps ticking alongside
    cfg(1, 1, 1);
    cfg(3, 1, 1);
    @(posedge clk);
    #1;
    bus.CFG_WE_I       = 1'b1;
    bus.CFG_CH_I       = CH_W'(1);
    bus.CFG_EN_I       = 1'b1;
    bus.CFG_INTERVAL_I = CNT_W'(4);
    bus.TICK_I         = 1'b1;
    k = cyc;
    q.push_back('{3, k + 2});
    tick_end(18);
    for (int i = 1; i <= 4; i++) begin
      tick_begin(k);
      if (i < 4) begin
        q.push_back('{3, k + 2});
      end else begin
        q.push_back('{1, k + 2});
        q.push_back('{3, k + 4});
      end
      tick_end(18);
    end
    check("t4_drain", q.size(), 0);
    cfg(3, 0, 0);

    // ch1 disabled while its event is presented
    bus.EVT_READY_I = 1'b0;
    plain_ticks(4, 18);
    check("t5_valid", int'(bus.EVT_VALID_O), 1);
    check("t5_ch", int'(bus.EVT_CH_O), 1);
    cfg(1, 0, 0);
    check("t5_pend_kept", int'(bus.PEND_O), 2);
    check("t5_valid_kept", int'(bus.EVT_VALID_O), 1);
    check("t5_ch_kept", int'(bus.EVT_CH_O), 1);
    @(posedge clk);
    #1;
    bus.EVT_READY_I = 1'b1;
    q.push_back('{1, cyc});
    idle(3);
    check("t5_pend_clr", int'(bus.PEND_O), 0);
    check("t5_valid_off", int'(bus.EVT_VALID_O), 0);
    plain_ticks(5, 8);
    check("t5_drain", q.size(), 0);
    check("t5_ovf", int'(bus.OVF_O), 0);

    // reset while an event is presented
    bus.EVT_READY_I = 1'b0;
    cfg(2, 1, 1);
    plain_ticks(1, 4);
    check("t6_valid_pre", int'(bus.EVT_VALID_O), 1);
    check("t6_ch_pre", int'(bus.EVT_CH_O), 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(bus.EVT_VALID_O), 0);
    check("t6_rst_ch", int'(bus.EVT_CH_O), 0);
    check("t6_rst_pend", int'(bus.PEND_O), 0);
    check("t6_rst_ovf", int'(bus.OVF_O), 0);
    idle(2);
    rst_n = 1'b1;
    bus.EVT_READY_I = 1'b1;
    plain_ticks(3, 8);
    check("t6_post_valid", int'(bus.EVT_VALID_O), 0);
    check("t6_post_pend", int'(bus.PEND_O), 0);
    check("t6_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
